// File: rtl/arb_fifo_pkg.sv
// Shared defaults and round-robin helpers for the arbitrated FIFO bank.
// The helpers work on a fixed MAX_CH-wide vector so every channel count up to 32 can share them.
package arb_fifo_pkg;

    localparam int NUM_FIFOS_DEF = 4;
    localparam int WIDTH_DEF     = 8;
    localparam int DEPTH_DEF     = 4;
    localparam int BURST_DEF     = 2;
    localparam int TAGWIDTH_DEF  = $clog2(NUM_FIFOS_DEF);
    localparam int MAX_CH        = 32;

    function automatic int next_rr(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

    // One-hot of the first set bit of vec at or above ptr, wrapping modulo n.
    function automatic logic [MAX_CH-1:0] first_set_from(input logic [MAX_CH-1:0] vec,
                                                         input int ptr,
                                                         input int n);
        logic [MAX_CH-1:0] onehot;
        logic              found;
        int                idx;
        onehot = '0;
        found  = 1'b0;
        for (int k = 0; k < MAX_CH; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && vec[idx[4:0]]) begin
                    onehot[idx[4:0]] = 1'b1;
                    found            = 1'b1;
                end
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/circular_pointer_fifo.sv
// Single-channel circular FIFO with wrap-bit pointers; pushes to a full FIFO
// and pops from an empty one are ignored.
module circular_pointer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered pointer; ARB_HOLD_EN adds burst holding
// of up to BURST consecutive grants to one channel.
module rr_arbiter
    import arb_fifo_pkg::*;
#(
    parameter int NUM_FIFOS = NUM_FIFOS_DEF,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
`ifdef ARB_HOLD_EN
    ,
    parameter int BURST     = BURST_DEF
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FIFOS-1:0] req,
    input  logic                 advance,
    output logic [NUM_FIFOS-1:0] gnt
);

    logic [TAGWIDTH-1:0] rr_ptr;
    logic [TAGWIDTH-1:0] gnt_idx;
    logic [MAX_CH-1:0]   search;
    logic                unused_search;

    always_comb begin
        search  = first_set_from(MAX_CH'(req), int'(rr_ptr), NUM_FIFOS);
        gnt     = advance ? search[NUM_FIFOS-1:0] : '0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (gnt[i]) begin
                gnt_idx = TAGWIDTH'(i);
            end
        end
    end

    assign unused_search = ^search;

`ifdef ARB_HOLD_EN
    localparam int CNT_W = $clog2(BURST + 1);

    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] cnt_next;

    // A nonzero count means rr_ptr still names the channel being held.
    always_comb begin
        cnt_next = CNT_W'(1);
        if (hold_cnt != '0 && gnt_idx == rr_ptr) begin
            cnt_next = hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else if (|gnt) begin
            if (int'(cnt_next) < BURST) begin
                rr_ptr   <= gnt_idx;
                hold_cnt <= cnt_next;
            end else begin
                rr_ptr   <= TAGWIDTH'(next_rr(int'(gnt_idx), NUM_FIFOS));
                hold_cnt <= '0;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (|gnt) begin
            rr_ptr <= TAGWIDTH'(next_rr(int'(gnt_idx), NUM_FIFOS));
        end
    end
`endif

endmodule

// File: rtl/rr_arbitrated_fifo_bank.sv
// NUM_FIFOS channel FIFOs drained round-robin into one registered valid/ready
// output tagged with the source channel. Optional macro: ARB_HOLD_EN (burst hold).
module rr_arbitrated_fifo_bank
    import arb_fifo_pkg::*;
#(
    parameter int NUM_FIFOS = NUM_FIFOS_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS),
    parameter int BURST     = BURST_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [TAGWIDTH-1:0]        push_sel,
    input  logic [NUM_FIFOS*WIDTH-1:0] flat_data_in,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           data_out,
    output logic [TAGWIDTH-1:0]        out_tag,
    output logic [NUM_FIFOS-1:0]       gnt,
    output logic [NUM_FIFOS-1:0]       full,
    output logic [NUM_FIFOS-1:0]       empty,
    output logic [NUM_FIFOS-1:0]       overflow
);

    logic [WIDTH-1:0]     head [NUM_FIFOS];
    logic [NUM_FIFOS-1:0] chan_push;
    logic                 load;
    logic [WIDTH-1:0]     sel_data;
    logic [TAGWIDTH-1:0]  sel_tag;

    for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_chan
        assign chan_push[i] = push && (push_sel == TAGWIDTH'(i));

        circular_pointer_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (chan_push[i]),
            .pop     (gnt[i]),
            .data_in (flat_data_in[i*WIDTH +: WIDTH]),
            .head    (head[i]),
            .full    (full[i]),
            .empty   (empty[i])
        );
    end

    // A word moves only when the output register is free or being consumed.
    assign load = (!out_valid || out_ready) && !(&empty);

`ifdef ARB_HOLD_EN
    rr_arbiter #(
        .NUM_FIFOS (NUM_FIFOS),
        .TAGWIDTH  (TAGWIDTH),
        .BURST     (BURST)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (~empty),
        .advance (load),
        .gnt     (gnt)
    );
`else
    localparam int unused_burst = BURST;

    rr_arbiter #(
        .NUM_FIFOS (NUM_FIFOS),
        .TAGWIDTH  (TAGWIDTH)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (~empty),
        .advance (load),
        .gnt     (gnt)
    );
`endif

    always_comb begin
        sel_data = '0;
        sel_tag  = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (gnt[i]) begin
                sel_data = head[i];
                sel_tag  = TAGWIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            out_tag   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            data_out  <= sel_data;
            out_tag   <= sel_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A drop is flagged even if the channel pops in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= '0;
        end else begin
            overflow <= overflow | (chan_push & full);
        end
    end

endmodule
